// File: rtl/arrow_track_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : arrow_track_engine_if                                 |
// | Purpose  : frame/button inputs and track/score outputs of one     |
// |            player's arrow track engine                            |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
interface arrow_track_engine_if;
  logic        vs;
  logic        start;
  logic [3:0]  buttons;
  logic [77:0] indexes;
  logic [1:0]  good_bad;
  logic [7:0]  score;
  logic        busy;

  modport master (
    output vs, start, buttons,
    input  indexes, good_bad, score, busy
  );

  modport slave (
    input  vs, start, buttons,
    output indexes, good_bad, score, busy
  );
endinterface
`default_nettype wire

// File: rtl/arrow_track_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : arrow_track_engine                                     |
// | Purpose  : per-player 26-slot scrolling arrow track, LFSR spawner, |
// |            hit-zone judge, score and good/bad indicator            |
// | Revision : 1.0                                                     |
// +------------------------------------------------------------------+
module arrow_track_engine #(
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned IND_FRAMES  = 30,
  parameter int unsigned NUM_ARROWS  = 64,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                vga_clk,
  input  logic                reset,
  arrow_track_engine_if.slave bus
);

  localparam logic [7:0] STEP_LAST   = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] IND_LAST    = 8'(IND_FRAMES - 1);
  localparam logic [7:0] ARROWS_LAST = 8'(NUM_ARROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        vs_q, vs_d;
  logic [3:0]  btn_q, btn_d;
  logic [77:0] slots_q, slots_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  good_bad_q, good_bad_d;
  logic        busy_q, busy_d;
  logic [7:0]  shift_cnt_q, shift_cnt_d;
  logic [7:0]  ind_cnt_q, ind_cnt_d;
  logic [7:0]  spawn_cnt_q, spawn_cnt_d;

  logic        tick;
  logic [3:0]  press;
  logic [2:0]  press_code;
  logic        active;
  logic        shift_now;
  logic        hit;
  logic [7:0]  lfsr_nx;
  logic [2:0]  spawn_code;

  // Next-state: frame tick, press judge, track shift, spawn and song FSM.
  always_comb begin
    state_d     = state_q;
    vs_d        = bus.vs;
    btn_d       = bus.buttons;
    slots_d     = slots_q;
    lfsr_d      = lfsr_q;
    score_d     = score_q;
    good_bad_d  = good_bad_q;
    shift_cnt_d = shift_cnt_q;
    ind_cnt_d   = ind_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    tick        = vs_q & ~bus.vs;
    press       = bus.buttons & ~btn_q;
    active      = (state_q == S_RUN) || (state_q == S_DRAIN);
    shift_now   = 1'b0;
    hit         = 1'b0;
    lfsr_nx     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    spawn_code  = lfsr_nx[7] ? ({1'b0, lfsr_nx[1:0]} + 3'd1) : 3'd0;

    case (press)
      4'b0001: press_code = 3'd1;
      4'b0010: press_code = 3'd2;
      4'b0100: press_code = 3'd3;
      4'b1000: press_code = 3'd4;
      default: press_code = 3'd0;
    endcase

    // Indicator ages only while shown; a new judgement below overrides this.
    if (tick && (good_bad_q != 2'b00)) begin
      if (ind_cnt_q == IND_LAST) begin
        good_bad_d = 2'b00;
        ind_cnt_d  = 8'd0;
      end else begin
        ind_cnt_d = ind_cnt_q + 8'd1;
      end
    end

    if (active) begin
      if (tick) begin
        if (shift_cnt_q == STEP_LAST) begin
          shift_cnt_d = 8'd0;
          shift_now   = 1'b1;
        end else begin
          shift_cnt_d = shift_cnt_q + 8'd1;
        end
      end

      // Judge against pre-shift slots; a matched slot is cleared before shifting.
      if (press != 4'b0000) begin
        ind_cnt_d = 8'd0;
        if ((press & (press - 4'd1)) != 4'b0000) begin
          good_bad_d = 2'b10;
        end else if (slots_q[2:0] == press_code) begin
          slots_d[2:0] = 3'd0;
          hit          = 1'b1;
        end else if (slots_q[5:3] == press_code) begin
          slots_d[5:3] = 3'd0;
          hit          = 1'b1;
        end else begin
          good_bad_d = 2'b10;
        end
        if (hit) begin
          good_bad_d = 2'b01;
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
        end
      end

      if (shift_now) begin
        lfsr_d  = lfsr_nx;
        slots_d = {(state_q == S_RUN) ? spawn_code : 3'd0, slots_d[77:3]};
        if (state_q == S_RUN) begin
          if (spawn_cnt_q == ARROWS_LAST) begin
            state_d     = S_DRAIN;
            spawn_cnt_d = 8'd0;
          end else begin
            spawn_cnt_d = spawn_cnt_q + 8'd1;
          end
        end
      end

      if ((state_q == S_DRAIN) && (slots_q == 78'd0)) begin
        state_d = S_DONE;
      end
    end else if (bus.start) begin
      state_d     = S_RUN;
      slots_d     = 78'd0;
      score_d     = 8'd0;
      good_bad_d  = 2'b00;
      shift_cnt_d = 8'd0;
      ind_cnt_d   = 8'd0;
      spawn_cnt_d = 8'd0;
      lfsr_d      = LFSR_SEED;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      btn_q       <= 4'd0;
      slots_q     <= 78'd0;
      lfsr_q      <= LFSR_SEED;
      score_q     <= 8'd0;
      good_bad_q  <= 2'b00;
      busy_q      <= 1'b0;
      shift_cnt_q <= 8'd0;
      ind_cnt_q   <= 8'd0;
      spawn_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      btn_q       <= btn_d;
      slots_q     <= slots_d;
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      good_bad_q  <= good_bad_d;
      busy_q      <= busy_d;
      shift_cnt_q <= shift_cnt_d;
      ind_cnt_q   <= ind_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  assign bus.indexes  = slots_q;
  assign bus.good_bad = good_bad_q;
  assign bus.score    = score_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_arrow_track_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_arrow_track_engine                                  |
// | Purpose  : directed self-checking bench for arrow_track_engine     |
// | Revision : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_arrow_track_engine;

  localparam int A_STEP = 1;
  localparam int A_IND  = 4;
  localparam int A_NUM  = 60;
  localparam int B_STEP = 3;
  localparam int B_IND  = 2;
  localparam int B_NUM  = 3;

  logic clk = 1'b0;
  logic rst;
  logic vs;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  arrow_track_engine_if ifa ();
  arrow_track_engine_if ifb ();

  assign ifa.vs = vs;
  assign ifb.vs = vs;

  arrow_track_engine #(
    .STEP_FRAMES(A_STEP), .IND_FRAMES(A_IND), .NUM_ARROWS(A_NUM), .LFSR_SEED(8'hA5)
  ) dut_a (
    .vga_clk(clk), .reset(rst), .bus(ifa.slave)
  );

  arrow_track_engine #(
    .STEP_FRAMES(B_STEP), .IND_FRAMES(B_IND), .NUM_ARROWS(B_NUM), .LFSR_SEED(8'hA5)
  ) dut_b (
    .vga_clk(clk), .reset(rst), .bus(ifb.slave)
  );

  // Reference model of dut_a: slots, LFSR, score, indicator, song state.
  int         m_slots [26];
  logic [7:0] m_lfsr;
  int         m_score, m_gb, m_ind, m_shifts, m_state;

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [77:0] m_pack();
    logic [77:0] p = '0;
    for (int i = 0; i < 26; i++) p[3*i +: 3] = 3'(m_slots[i]);
    return p;
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < 26; i++) if (m_slots[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_start();
    for (int i = 0; i < 26; i++) m_slots[i] = 0;
    m_lfsr = 8'hA5; m_score = 0; m_gb = 0; m_ind = 0; m_shifts = 0; m_state = 1;
  endtask

  task automatic m_settle();
    if (m_state == 2 && m_empty()) m_state = 3;
  endtask

  task automatic m_frame(input bit judged);
    if (!judged && m_gb != 0) begin
      m_ind++;
      if (m_ind == A_IND) begin m_gb = 0; m_ind = 0; end
    end
    if (m_state == 1 || m_state == 2) begin
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      for (int i = 0; i < 25; i++) m_slots[i] = m_slots[i+1];
      m_slots[25] = (m_state == 1 && m_lfsr[7]) ? int'(m_lfsr[1:0]) + 1 : 0;
      if (m_state == 1) begin
        m_shifts++;
        if (m_shifts == A_NUM) m_state = 2;
      end
    end
  endtask

  task automatic m_press(input logic [3:0] b);
    int d;
    if (m_state != 1 && m_state != 2) return;
    m_ind = 0;
    if ($countones(b) > 1) begin m_gb = 2; return; end
    d = (b == 4'b0001) ? 1 : (b == 4'b0010) ? 2 : (b == 4'b0100) ? 3 : 4;
    if (m_slots[0] == d) begin
      m_slots[0] = 0; m_gb = 1; if (m_score < 255) m_score++;
    end else if (m_slots[1] == d) begin
      m_slots[1] = 0; m_gb = 1; if (m_score < 255) m_score++;
    end else begin
      m_gb = 2;
    end
  endtask

  task automatic check_a(input string tag);
    check({tag, "_idx"},   ifa.indexes, m_pack());
    check({tag, "_gb"},    78'(ifa.good_bad), 78'(m_gb));
    check({tag, "_score"}, 78'(ifa.score), 78'(m_score));
    check({tag, "_busy"},  78'(ifa.busy), 78'((m_state == 1 || m_state == 2) ? 1 : 0));
  endtask

  // One vs pulse (one tick), then one settling cycle; returns on a negedge.
  task automatic frame();
    @(negedge clk) vs = 1'b0;
    @(negedge clk) vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk) ifa.buttons = b;
    @(negedge clk) ifa.buttons = 4'b0000;
    @(negedge clk);
  endtask

  task automatic press_frame(input logic [3:0] b);
    @(negedge clk) begin vs = 1'b0; ifa.buttons = b; end
    @(negedge clk) begin vs = 1'b1; ifa.buttons = 4'b0000; end
    @(negedge clk);
  endtask

  task automatic pulse_start_a();
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int d;
    rst = 1'b1; vs = 1'b1;
    ifa.start = 1'b0; ifa.buttons = 4'b0000;
    ifb.start = 1'b0; ifb.buttons = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state survives vs pulses while idle.
    frames(10);
    check("rst_idx",   ifa.indexes, 78'd0);
    check("rst_gb",    78'(ifa.good_bad), 78'd0);
    check("rst_score", 78'(ifa.score), 78'd0);
    check("rst_busy",  78'(ifa.busy), 78'd0);
    check("rst_busy_b", 78'(ifb.busy), 78'd0);

    // dut_b: STEP_FRAMES=3, NUM_ARROWS=3 -> shifts on ticks 3,6,9; one arrow (code 2) from shift 2.
    @(negedge clk) ifb.start = 1'b1;
    @(negedge clk) ifb.start = 1'b0;
    @(negedge clk);
    check("b_busy_start", 78'(ifb.busy), 78'd1);
    frames(5);
    check("b_t5",  ifb.indexes, 78'd0);
    frames(1);
    check("b_t6",  ifb.indexes, 78'd2 << 75);
    frames(2);
    check("b_t8",  ifb.indexes, 78'd2 << 75);
    frames(1);
    check("b_t9",  ifb.indexes, 78'd2 << 72);
    frames(6);
    check("b_t15", ifb.indexes, 78'd2 << 66);
    check("b_t15_busy", 78'(ifb.busy), 78'd1);
    frames(66);
    check("b_t81", ifb.indexes, 78'd2);
    check("b_t81_busy", 78'(ifb.busy), 78'd1);
    frames(3);
    check("b_t84", ifb.indexes, 78'd0);
    check("b_t84_busy", 78'(ifb.busy), 78'd0);
    check("b_score", 78'(ifb.score), 78'd0);

    // dut_a: start and follow the track shift by shift.
    pulse_start_a();
    m_start();
    check_a("a_start");
    for (int k = 0; k < 27; k++) begin
      frame(); m_frame(1'b0); m_settle();
      check_a("a_track");
    end

    // Hit on slot0 (code 2 = up), then indicator ages out after A_IND ticks.
    press(4'b0010); m_press(4'b0010); m_settle();
    check_a("a_hit0");
    check("a_hit0_score", 78'(ifa.score), 78'd1);
    check("a_hit0_slot0", 78'(ifa.indexes[2:0]), 78'd0);
    for (int k = 0; k < A_IND; k++) begin
      check("a_ind_held", 78'(ifa.good_bad), 78'd1);
      frame(); m_frame(1'b0); m_settle();
      check_a("a_ind");
    end
    check("a_ind_clear", 78'(ifa.good_bad), 78'd0);

    // Two buttons rising together -> bad, score unchanged.
    press(4'b0011); m_press(4'b0011); m_settle();
    check_a("a_multi");
    check("a_multi_gb", 78'(ifa.good_bad), 78'd2);
    check("a_multi_score", 78'(ifa.score), 78'd1);

    // Held button judges once only: indicator must age out during the hold.
    @(negedge clk) ifa.buttons = 4'b0001;
    m_press(4'b0001); m_settle();
    @(negedge clk);
    @(negedge clk);
    check_a("a_hold_first");
    for (int k = 0; k < 10; k++) begin
      frame(); m_frame(1'b0); m_settle();
    end
    repeat (70) @(negedge clk);
    check_a("a_hold_end");
    check("a_hold_gb", 78'(ifa.good_bad), 78'd0);
    @(negedge clk) ifa.buttons = 4'b0000;
    @(negedge clk);

    // Press matching slot1 on the shift cycle.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if ((m_state == 1 || m_state == 2) && m_slots[1] != 0 && m_slots[1] != m_slots[0]) begin
        found = 1'b1;
      end else begin
        frame(); m_frame(1'b0); m_settle();
      end
    end
    check("a_slot1_found", 78'(found), 78'd1);
    if (found) begin
      d = m_slots[1];
      press_frame(4'(1 << (d - 1)));
      m_press(4'(1 << (d - 1))); m_frame(1'b1); m_settle();
      check_a("a_slot1_shift");
      check("a_slot1_gb", 78'(ifa.good_bad), 78'd1);
      check("a_slot1_slot0", 78'(ifa.indexes[2:0]), 78'd0);
    end

    // Run the song out: RUN -> DRAIN -> DONE, busy falls when track empties.
    for (int k = 0; k < 200 && m_state != 3; k++) begin
      frame(); m_frame(1'b0); m_settle();
      check_a("a_song");
    end
    check("a_done_busy", 78'(ifa.busy), 78'd0);
    check("a_done_idx", ifa.indexes, 78'd0);

    // start in DONE restarts from a clean state with the seed reloaded.
    pulse_start_a();
    m_start();
    check_a("a_restart");
    for (int k = 0; k < 3; k++) begin
      frame(); m_frame(1'b0); m_settle();
      check_a("a_restart_track");
    end
    press(4'b1100); m_press(4'b1100); m_settle();
    check_a("a_restart_bad");

    // Reset mid-song clears everything by the next cycle.
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("a_mrst_idx",   ifa.indexes, 78'd0);
    check("a_mrst_gb",    78'(ifa.good_bad), 78'd0);
    check("a_mrst_score", 78'(ifa.score), 78'd0);
    check("a_mrst_busy",  78'(ifa.busy), 78'd0);
    rst = 1'b0;
    frames(2);
    check("a_mrst_idle_idx", ifa.indexes, 78'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
